// File: rtl/reg_file_sequencer_if.sv
// Instruction handshake plus 8x8 register-file port of the sequencer.
// Optional ZERO flag is present only when REGSEQ_ZERO_FLAG_EN is defined.
interface reg_file_sequencer_if;
    logic [31:0] INSTR;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [7:0]  REG_OUT1;
    logic [7:0]  REG_OUT2;
    logic [2:0]  REG_OUT1ADDR;
    logic [2:0]  REG_OUT2ADDR;
    logic [2:0]  REG_INADDR;
    logic [7:0]  REG_IN;
    logic        REG_WRITE;
    logic        DONE;
    logic        ILLEGAL;
`ifdef REGSEQ_ZERO_FLAG_EN
    logic        ZERO;

    modport master (
        input  INSTR, INSTR_VALID, REG_OUT1, REG_OUT2,
        output INSTR_READY, REG_OUT1ADDR, REG_OUT2ADDR, REG_INADDR, REG_IN,
        output REG_WRITE, DONE, ILLEGAL, ZERO
    );
    modport slave (
        output INSTR, INSTR_VALID, REG_OUT1, REG_OUT2,
        input  INSTR_READY, REG_OUT1ADDR, REG_OUT2ADDR, REG_INADDR, REG_IN,
        input  REG_WRITE, DONE, ILLEGAL, ZERO
    );
`else
    modport master (
        input  INSTR, INSTR_VALID, REG_OUT1, REG_OUT2,
        output INSTR_READY, REG_OUT1ADDR, REG_OUT2ADDR, REG_INADDR, REG_IN,
        output REG_WRITE, DONE, ILLEGAL
    );
    modport slave (
        output INSTR, INSTR_VALID, REG_OUT1, REG_OUT2,
        input  INSTR_READY, REG_OUT1ADDR, REG_OUT2ADDR, REG_INADDR, REG_IN,
        input  REG_WRITE, DONE, ILLEGAL
    );
`endif
endinterface

// File: rtl/reg_file_sequencer.sv
// Register-file sequencer: accepts one decoded instruction, reads operands, executes, writes back.
// Optional feature macro: REGSEQ_ZERO_FLAG_EN (adds the ZERO result flag).
module reg_file_sequencer #(
    parameter int READ_WAIT = 1,
    parameter int WB_GAP    = 0
) (
    input logic                  CLK,
    input logic                  RESET,
    reg_file_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, READ, EXEC, WB, GAP} state_t;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;

    state_t      state, state_nxt;
    logic [2:0]  cnt;
    logic [7:0]  op_p0;
    logic [2:0]  dest_p0;
    logic [7:0]  imm_p0;
    logic [7:0]  opa_p1, opb_p1;
    logic [7:0]  result_p2;
    logic [2:0]  rd1_addr, rd2_addr;
    logic        illegal_q;
    logic        ready, accept, legal, wb_act;
    logic        unused_instr_bits;

    function automatic logic is_legal(input logic [7:0] op);
        return op <= OP_OR;
    endfunction

    // Results wrap modulo 2^8; carry and borrow are dropped.
    function automatic logic [7:0] alu(input logic [7:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] imm);
        case (op)
            OP_LOADI: return imm;
            OP_MOV:   return b;
            OP_ADD:   return a + b;
            OP_SUB:   return a - b;
            OP_AND:   return a & b;
            OP_OR:    return a | b;
            default:  return 8'h00;
        endcase
    endfunction

    assign unused_instr_bits = ^{bus.INSTR[23:19], bus.INSTR[15:11]};

    assign ready  = (state == IDLE) && !RESET;
    assign accept = ready && bus.INSTR_VALID;
    assign legal  = is_legal(bus.INSTR[31:24]);
    assign wb_act = (state == WB) && !RESET;

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && legal)
                      state_nxt = (bus.INSTR[31:24] == OP_LOADI) ? EXEC : READ;
            READ: if (cnt == 3'(READ_WAIT - 1)) state_nxt = EXEC;
            EXEC: state_nxt = WB;
            WB:   state_nxt = (WB_GAP > 0) ? GAP : IDLE;
            GAP:  if (cnt == 3'(WB_GAP - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // p0: instruction latch at transfer; p1: operand capture; p2: ALU result
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt       <= '0;
            op_p0     <= '0;
            dest_p0   <= '0;
            imm_p0    <= '0;
            opa_p1    <= '0;
            opb_p1    <= '0;
            result_p2 <= '0;
            rd1_addr  <= '0;
            rd2_addr  <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (legal) begin
                        op_p0   <= bus.INSTR[31:24];
                        dest_p0 <= bus.INSTR[18:16];
                        imm_p0  <= bus.INSTR[7:0];
                        cnt     <= '0;
                        if (bus.INSTR[31:24] != OP_LOADI) begin
                            rd1_addr <= bus.INSTR[10:8];
                            rd2_addr <= bus.INSTR[2:0];
                        end
                    end else begin
                        illegal_q <= 1'b1;
                    end
                end
                READ: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'(READ_WAIT - 1)) begin
                        opa_p1 <= bus.REG_OUT1;
                        opb_p1 <= bus.REG_OUT2;
                    end
                end
                EXEC: result_p2 <= alu(op_p0, opa_p1, opb_p1, imm_p0);
                WB:   cnt <= '0;
                GAP:  cnt <= cnt + 3'd1;
                default: cnt <= '0;
            endcase
        end
    end

`ifdef REGSEQ_ZERO_FLAG_EN
    logic zero_q;
    always_ff @(posedge CLK) begin
        if (RESET)               zero_q <= 1'b0;
        else if (state == WB)    zero_q <= (result_p2 == 8'h00);
    end
    assign bus.ZERO = zero_q;
`endif

    assign bus.INSTR_READY  = ready;
    assign bus.REG_OUT1ADDR = rd1_addr;
    assign bus.REG_OUT2ADDR = rd2_addr;
    assign bus.REG_WRITE    = wb_act;
    assign bus.DONE         = wb_act;
    assign bus.REG_INADDR   = wb_act ? dest_p0 : 3'd0;
    assign bus.REG_IN       = wb_act ? result_p2 : 8'd0;
    assign bus.ILLEGAL      = illegal_q;
endmodule

// File: tb/tb_reg_file_sequencer.sv
// Directed bench for reg_file_sequencer: default timing instance with a register-file model,
// plus a READ_WAIT=3 / WB_GAP=2 instance for timing.
module tb_reg_file_sequencer;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] rf [8];

    always #5 CLK = ~CLK;

    reg_file_sequencer_if bus_a();
    reg_file_sequencer_if bus_b();

    reg_file_sequencer #(.READ_WAIT(1), .WB_GAP(0)) dut_a (
        .CLK(CLK), .RESET(RESET), .bus(bus_a.master));
    reg_file_sequencer #(.READ_WAIT(3), .WB_GAP(2)) dut_b (
        .CLK(CLK), .RESET(RESET), .bus(bus_b.master));

    // Register file attached to instance A
    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
        end else if (bus_a.REG_WRITE) begin
            rf[bus_a.REG_INADDR] <= bus_a.REG_IN;
        end
    end
    assign bus_a.REG_OUT1 = rf[bus_a.REG_OUT1ADDR];
    assign bus_a.REG_OUT2 = rf[bus_a.REG_OUT2ADDR];
    assign bus_b.REG_OUT1 = 8'h11;
    assign bus_b.REG_OUT2 = 8'h22;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [7:0] op, input logic [2:0] d,
                                       input logic [2:0] s1, input logic [7:0] imm);
        return {op, 5'b0, d, 5'b0, s1, imm};
    endfunction

    task automatic send(input logic [31:0] instr);
        int w = 0;
        while (!bus_a.INSTR_READY && w < 20) begin
            tick();
            w++;
        end
        if (!bus_a.INSTR_READY) check("send_timeout", 32'd0, 32'd1);
        bus_a.INSTR       = instr;
        bus_a.INSTR_VALID = 1'b1;
        tick();
        bus_a.INSTR_VALID = 1'b0;
        bus_a.INSTR       = 32'hFFFF_FFFF;
    endtask

    task automatic exec_chk(input string tag, input logic [31:0] instr, input int lat,
                            input logic [2:0] dest, input logic [7:0] val);
        send(instr);
        repeat (lat - 1) tick();
        check({tag, "_we"},   32'(bus_a.REG_WRITE),  32'd1);
        check({tag, "_addr"}, 32'(bus_a.REG_INADDR), 32'(dest));
        check({tag, "_data"}, 32'(bus_a.REG_IN),     32'(val));
        check({tag, "_done"}, 32'(bus_a.DONE),       32'd1);
        tick();
        check({tag, "_we_off"}, 32'(bus_a.REG_WRITE), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb_at, low, back;
        bus_a.INSTR = '0; bus_a.INSTR_VALID = 1'b0;
        bus_b.INSTR = '0; bus_b.INSTR_VALID = 1'b0;
        tick(); tick();
        RESET = 1'b0;
        #1;
        check("rst_ready",  32'(bus_a.INSTR_READY),  32'd1);
        check("rst_we",     32'(bus_a.REG_WRITE),    32'd0);
        check("rst_done",   32'(bus_a.DONE),         32'd0);
        check("rst_ill",    32'(bus_a.ILLEGAL),      32'd0);
        check("rst_a1",     32'(bus_a.REG_OUT1ADDR), 32'd0);
        check("rst_a2",     32'(bus_a.REG_OUT2ADDR), 32'd0);
        check("rst_in",     32'(bus_a.REG_IN),       32'd0);
        check("rst_b_ready",32'(bus_b.INSTR_READY),  32'd1);
`ifdef REGSEQ_ZERO_FLAG_EN
        check("rst_zero",   32'(bus_a.ZERO),         32'd0);
`endif

        // Reset while an add sits in READ
        send(mk(8'h02, 3'd4, 3'd1, 8'h02));
        check("t1_read_a1", 32'(bus_a.REG_OUT1ADDR), 32'd1);
        check("t1_ready_lo",32'(bus_a.INSTR_READY),  32'd0);
        RESET = 1'b1;
        #1;
        check("t1_we_rst",  32'(bus_a.REG_WRITE),    32'd0);
        tick();
        RESET = 1'b0;
        #1;
        check("t1_we_n1",   32'(bus_a.REG_WRITE),    32'd0);
        check("t1_ready",   32'(bus_a.INSTR_READY),  32'd1);
        tick();
        check("t1_we_n2",   32'(bus_a.REG_WRITE),    32'd0);
        check("t1_done_n2", 32'(bus_a.DONE),         32'd0);

        // loadi r3,0x2A: WB two cycles after transfer
        send(mk(8'h00, 3'd3, 3'd0, 8'h2A));
        check("t2_we_c1",   32'(bus_a.REG_WRITE),    32'd0);
        tick();
        check("t2_we",      32'(bus_a.REG_WRITE),    32'd1);
        check("t2_addr",    32'(bus_a.REG_INADDR),   32'd3);
        check("t2_data",    32'(bus_a.REG_IN),       32'h2A);
        check("t2_done",    32'(bus_a.DONE),         32'd1);
        tick();
        check("t2_idle",    32'(bus_a.INSTR_READY),  32'd1);
        check("t2_in_zero", 32'(bus_a.REG_IN),       32'd0);

        // ALU ops with r1=F0, r2=20
        exec_chk("ld_r1", mk(8'h00, 3'd1, 3'd0, 8'hF0), 2, 3'd1, 8'hF0);
        exec_chk("ld_r2", mk(8'h00, 3'd2, 3'd0, 8'h20), 2, 3'd2, 8'h20);
        exec_chk("add",   mk(8'h02, 3'd4, 3'd1, 8'h02), 3, 3'd4, 8'h10);
        check("hold_a1",    32'(bus_a.REG_OUT1ADDR), 32'd1);
        check("hold_a2",    32'(bus_a.REG_OUT2ADDR), 32'd2);
`ifdef REGSEQ_ZERO_FLAG_EN
        check("zero_clr",   32'(bus_a.ZERO),         32'd0);
`endif
        exec_chk("sub",   mk(8'h03, 3'd6, 3'd2, 8'h01), 3, 3'd6, 8'h30);
        exec_chk("and",   mk(8'h04, 3'd7, 3'd1, 8'h02), 3, 3'd7, 8'h20);
        exec_chk("or",    mk(8'h05, 3'd0, 3'd1, 8'h02), 3, 3'd0, 8'hF0);
        exec_chk("mov",   mk(8'h01, 3'd3, 3'd0, 8'h02), 3, 3'd3, 8'h20);
        exec_chk("subz",  mk(8'h03, 3'd5, 3'd1, 8'h01), 3, 3'd5, 8'h00);
`ifdef REGSEQ_ZERO_FLAG_EN
        check("zero_set",   32'(bus_a.ZERO),         32'd1);
`endif

        // Illegal opcode
        send(mk(8'h07, 3'd2, 3'd0, 8'h00));
        check("ill_pulse",  32'(bus_a.ILLEGAL),      32'd1);
        check("ill_we",     32'(bus_a.REG_WRITE),    32'd0);
        check("ill_ready",  32'(bus_a.INSTR_READY),  32'd1);
        tick();
        check("ill_clear",  32'(bus_a.ILLEGAL),      32'd0);
        check("ill_we2",    32'(bus_a.REG_WRITE),    32'd0);
`ifdef REGSEQ_ZERO_FLAG_EN
        check("zero_hold",  32'(bus_a.ZERO),         32'd1);
`endif
        exec_chk("post_ill", mk(8'h00, 3'd2, 3'd0, 8'h99), 2, 3'd2, 8'h99);

        // Back-to-back dependency: loadi r1,5 then add r1,r1,r1
        exec_chk("dep_ld",  mk(8'h00, 3'd1, 3'd0, 8'h05), 2, 3'd1, 8'h05);
        check("dep_ready",  32'(bus_a.INSTR_READY),  32'd1);
        exec_chk("dep_add", mk(8'h02, 3'd1, 3'd1, 8'h01), 3, 3'd1, 8'h0A);

        // READ_WAIT=3, WB_GAP=2 timing on instance B
        check("b_ready0",   32'(bus_b.INSTR_READY),  32'd1);
        bus_b.INSTR       = mk(8'h02, 3'd6, 3'd1, 8'h02);
        bus_b.INSTR_VALID = 1'b1;
        tick();
        bus_b.INSTR_VALID = 1'b0;
        bus_b.INSTR       = 32'hFFFF_FFFF;
        check("b_a1",       32'(bus_b.REG_OUT1ADDR), 32'd1);
        check("b_a2",       32'(bus_b.REG_OUT2ADDR), 32'd2);
        wb_at = 0; low = 0; back = 0;
        for (int k = 1; k <= 20; k++) begin
            if (bus_b.REG_WRITE && wb_at == 0) begin
                wb_at = k;
                check("b_data", 32'(bus_b.REG_IN),     32'h33);
                check("b_addr", 32'(bus_b.REG_INADDR), 32'd6);
            end
            if (!bus_b.INSTR_READY) begin
                low++;
            end else begin
                back = k;
                break;
            end
            tick();
        end
        check("b_wb_cycle", 32'(wb_at), 32'd5);
        check("b_ready_low",32'(low),   32'd7);
        check("b_period",   32'(back),  32'd8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
